// File: rtl/pipeline_skid_stage_pkg.sv
// Shared state encoding for the skid stage. The encoding equals the entry count,
// so occupancy is the state register itself.
package pipeline_skid_stage_pkg;

  localparam int unsigned OccWidth = 2;

  typedef enum logic [OccWidth-1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/stage_data_reg.sv
// Payload register with load enable and synchronous reset to a fixed bubble value.
module stage_data_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= RESET_VALUE;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipeline_skid_stage.sv
// Valid/ready pipeline stage: 2-entry skid buffer (SKID=1, registered in_ready)
// or a single pass-through register (SKID=0, combinational in_ready).
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      SKID         = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready,
  output logic [OccWidth-1:0] occupancy
);

  skid_state_e      state_q, state_d;
  logic             in_xfer, out_xfer;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (in_xfer) state_d = StOne;
      StOne: begin
        if (in_xfer && !out_xfer) begin
          state_d = StTwo;
        end else if (!in_xfer && out_xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo:   if (out_xfer) state_d = StOne;
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  // Main register always holds the head; skid only catches the second entry.
  always_comb begin
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = in_data;
    out_valid = (state_q != StEmpty);
    occupancy = state_q;
    out_data  = out_valid ? main_q : BUBBLE_VALUE;
    if (!flush) begin
      unique case (state_q)
        StEmpty: main_en = in_xfer;
        StOne: begin
          main_en = in_xfer & out_xfer;
          skid_en = in_xfer & ~out_xfer;
        end
        StTwo: begin
          main_en = out_xfer;
          main_d  = skid_q;
        end
        default: ;
      endcase
    end
  end

  stage_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(BUBBLE_VALUE)
  ) u_main_reg (
    .clk_i(clk),
    .rst_i(rst),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  stage_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(BUBBLE_VALUE)
  ) u_skid_reg (
    .clk_i(clk),
    .rst_i(rst),
    .en_i (skid_en),
    .d_i  (in_data),
    .q_o  (skid_q)
  );

  if (SKID != 0) begin : g_skid
    // Registered so that out_ready never reaches in_ready combinationally.
    logic in_ready_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != StTwo);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_single
    assign in_ready = out_ready | ~out_valid;
  end

endmodule

// File: doc/pipeline_skid_stage.md
PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the payload bit width, legal range 1..256.
REQ-002 SHALL have parameter SKID, default 1, meaning 1 selects the 2-entry skid mode and 0 selects the single-register mode.
REQ-003 SHALL have parameter BUBBLE_VALUE, default 0 (WIDTH bits), meaning the value driven on out_data when no entry is valid.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  discards all held entries this cycle.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  stage accepts in_data this cycle.
REQ-011 out_valid  output  1  out_data holds a valid entry.
REQ-012 out_data  output  WIDTH  head entry payload, or BUBBLE_VALUE when out_valid=0.
REQ-013 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-014 occupancy  output  2  number of held entries (0..2).

Function
REQ-015 Input transfer SHALL occur on a rising edge with in_valid&in_ready; output transfer SHALL occur with out_valid&out_ready.
REQ-016 Entries SHALL leave in strict arrival order; no payload SHALL be duplicated or dropped, except on flush or rst.
REQ-017 SKID=1 SHALL implement states EMPTY(occ 0), ONE(occ 1), TWO(occ 2), with main register = head and skid register = second entry.
REQ-018 SKID=1 transitions: EMPTY+in -> ONE; ONE+in+out -> ONE; ONE+in only -> TWO; ONE+out only -> EMPTY; TWO+out -> ONE (skid moves to main same edge); otherwise hold.
REQ-019 SKID=1 in_ready SHALL be a pure register output equal to (state != TWO), with no combinational path from out_ready.
REQ-020 SKID=0 SHALL hold at most one entry, and in_ready SHALL be out_ready | ~out_valid (combinational).
REQ-021 Latency SHALL be 1 cycle from input transfer to out_valid when the stage was empty.
REQ-022 Full throughput SHALL be one transfer per cycle while out_ready stays 1.
REQ-023 out_valid SHALL equal (occupancy != 0).
REQ-024 flush SHALL set state EMPTY on the next edge and SHALL take priority over any simultaneous input or output transfer; an in_valid offered in the flush cycle is discarded.
REQ-025 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 in_data SHALL be ignored when in_valid=0.

Reset
REQ-027 rst=1 at a rising edge SHALL force EMPTY, occupancy=0, out_valid=0, out_data=BUBBLE_VALUE, and in_ready=1 (SKID=1) from the next cycle.
REQ-028 Reset SHALL override flush and all transfers, including mid-stream with 2 entries held, and SHALL discard both entries.
REQ-029 Payload registers SHALL also reset to BUBBLE_VALUE so that no X reaches out_data.

Structure
REQ-030 State encodings (EMPTY/ONE/TWO) and the occupancy width SHALL live in the shared bus/defines include next to the existing bus-width macros.
REQ-031 One sub-module, stage_data_reg (WIDTH-parameterised, with enable and sync reset to BUBBLE_VALUE), SHALL be instantiated for both the main and skid registers.
REQ-032 The existing per-field pipeline registers SHALL be replaceable by a single instance, with the concatenated fields as in_data.

Verification (WIDTH=32, SKID=1 unless noted)
REQ-033 Stream: in_valid=1 with data 1..8 and out_ready=1 -> out_data 1..8 on consecutive cycles starting one cycle later, with occupancy staying 1.
REQ-034 Backpressure: send 0xA, 0xB with out_ready=0 -> occupancy=2 and in_ready=0 the cycle after; raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after the first pop.
REQ-035 Flush collision: state TWO with in_valid=1 (0xC), out_ready=1, flush=1 -> next cycle occupancy=0, out_valid=0, out_data=0, 0xC never appears.
REQ-036 Reset mid-stream: occupancy=2, assert rst for one cycle -> out_valid=0, out_data=BUBBLE_VALUE, in_ready=1, and no old data emerges afterward.
REQ-037 Random: random in_valid/out_ready for 10k cycles (SKID=0 and 1) -> a scoreboard shows in-order, lossless delivery, and for SKID=1 in_ready never depends combinationally on out_ready.
